// File: rtl/e32_regfile_sb_if.sv
`default_nettype none
// ============================================================================
// e32_regfile_sb_if : decode/writeback/hazard bundle for e32_regfile_sb
// Revision 1.0 - initial release
// ============================================================================
interface e32_regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [NREAD*AW-1:0]   rd_sel;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_sel;
    logic [XLEN-1:0]       wr_data;
    logic                  iss_en;
    logic [AW-1:0]         iss_sel;
    logic                  flush;
    logic [CW-1:0]         pend_cnt;
    logic                  wb_stray;

    modport master (
        output rd_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel, flush,
        input  rd_data, rd_busy, pend_cnt, wb_stray
    );

    modport slave (
        input  rd_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel, flush,
        output rd_data, rd_busy, pend_cnt, wb_stray
    );
endinterface
`default_nettype wire

// File: rtl/e32_regfile_sb.sv
`default_nettype none
// ============================================================================
// e32_regfile_sb : N-read register file with bypass and pending-write scoreboard
// Revision 1.0 - initial release
// ============================================================================
module e32_regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    e32_regfile_sb_if.slave    bus
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [NREGS-1:0]      pend_q;
    logic [NREGS-1:0]      pend_d;
    logic [CW-1:0]         pend_cnt_q;
    logic [CW-1:0]         pend_cnt_d;
    logic                  wb_stray_q;
    logic                  wb_stray_d;
    logic                  wr_live;
    logic                  iss_live;
    logic [NREAD*XLEN-1:0] rd_data_w;
    logic [NREAD-1:0]      rd_busy_w;

    // Writes and issues to the hardwired zero register are dropped outright.
    assign wr_live  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_sel  == '0));
    assign iss_live = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_sel == '0));

    // Later steps override earlier ones: flush, then writeback clear, then issue set.
    always_comb begin
        pend_d = pend_q;
        if (bus.flush) pend_d = '0;
        if (wr_live)   pend_d[bus.wr_sel]  = 1'b0;
        if (iss_live)  pend_d[bus.iss_sel] = 1'b1;
        if (ZERO_REG != 0) pend_d[0] = 1'b0;
        pend_cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            pend_cnt_d = pend_cnt_d + CW'(pend_d[i]);
        end
        wb_stray_d = wr_live && !pend_q[bus.wr_sel];
    end

    always_comb begin
        rd_data_w = '0;
        rd_busy_w = '0;
        for (int p = 0; p < NREAD; p++) begin
            logic [AW-1:0] sel;
            logic          hit;
            sel = bus.rd_sel[p*AW +: AW];
            hit = (BYPASS != 0) && wr_live && (bus.wr_sel == sel);
            if ((ZERO_REG != 0) && (sel == '0)) begin
                rd_data_w[p*XLEN +: XLEN] = '0;
            end else if (hit) begin
                rd_data_w[p*XLEN +: XLEN] = bus.wr_data;
            end else begin
                rd_data_w[p*XLEN +: XLEN] = regs_q[sel];
            end
            rd_busy_w[p] = pend_q[sel] && !hit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
            wb_stray_q <= 1'b0;
        end else begin
            if (wr_live) regs_q[bus.wr_sel] <= bus.wr_data;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
            wb_stray_q <= wb_stray_d;
        end
    end

    assign bus.rd_data  = rd_data_w;
    assign bus.rd_busy  = rd_busy_w;
    assign bus.pend_cnt = pend_cnt_q;
    assign bus.wb_stray = wb_stray_q;
endmodule
`default_nettype wire

// File: tb/tb_e32_regfile_sb.sv
`default_nettype none
// ============================================================================
// tb_e32_regfile_sb : directed self-checking bench, bypass and non-bypass DUTs
// Revision 1.0 - initial release
// ============================================================================
module tb_e32_regfile_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    e32_regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) ifb ();
    e32_regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) ifn ();

    e32_regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .reset(rst_n), .bus(ifb.slave)
    );
    e32_regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
        .clk(clk), .reset(rst_n), .bus(ifn.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic we, input logic [4:0] ws, input logic [31:0] wd,
                       input logic ie, input logic [4:0] isel, input logic fl,
                       input logic [4:0] s0, input logic [4:0] s1);
        ifb.wr_en = we;  ifb.wr_sel = ws;  ifb.wr_data = wd;
        ifb.iss_en = ie; ifb.iss_sel = isel; ifb.flush = fl;
        ifb.rd_sel = {s1, s0};
        ifn.wr_en = we;  ifn.wr_sel = ws;  ifn.wr_data = wd;
        ifn.iss_en = ie; ifn.iss_sel = isel; ifn.flush = fl;
        ifn.rd_sel = {s1, s0};
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Reset state across every register on both ports
        for (int r = 0; r < 32; r++) begin
            drv(0, 0, 0, 0, 0, 0, 5'(r), 5'(31 - r));
            #1;
            chk("reset_rd_data", 64'(ifb.rd_data), 64'h0);
            chk("reset_rd_busy", 64'(ifb.rd_busy), 64'h0);
        end
        chk("reset_pend_cnt", 64'(ifb.pend_cnt), 64'h0);
        chk("reset_wb_stray", 64'(ifb.wb_stray), 64'h0);

        // r5 write: bypass visible now, non-bypass next cycle
        drv(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        @(negedge clk);
        chk("byp_same_cycle", 64'(ifb.rd_data[31:0]), 64'hDEADBEEF);
        chk("nobyp_old_value", 64'(ifn.rd_data[31:0]), 64'h0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 5, 0);
        @(negedge clk);
        chk("nobyp_next_cycle", 64'(ifn.rd_data[31:0]), 64'hDEADBEEF);
        chk("byp_stored", 64'(ifb.rd_data[31:0]), 64'hDEADBEEF);

        // Issue r7, then writeback r7
        cyc();
        drv(0, 0, 0, 1, 7, 0, 7, 0);
        @(negedge clk);
        chk("iss_busy_not_yet", 64'(ifb.rd_busy[0]), 64'h0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        chk("iss_busy", 64'(ifb.rd_busy[0]), 64'h1);
        chk("iss_pend_cnt", 64'(ifb.pend_cnt), 64'h1);
        chk("iss_busy_nb", 64'(ifn.rd_busy[0]), 64'h1);
        cyc();
        drv(1, 7, 32'h12, 0, 0, 0, 7, 0);
        @(negedge clk);
        chk("wb_busy_drop_byp", 64'(ifb.rd_busy[0]), 64'h0);
        chk("wb_data_byp", 64'(ifb.rd_data[31:0]), 64'h12);
        chk("wb_busy_hold_nb", 64'(ifn.rd_busy[0]), 64'h1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        chk("wb_pend_cnt", 64'(ifb.pend_cnt), 64'h0);
        chk("wb_no_stray", 64'(ifb.wb_stray), 64'h0);
        chk("wb_busy_drop_nb", 64'(ifn.rd_busy[0]), 64'h0);
        chk("wb_data_nb", 64'(ifn.rd_data[31:0]), 64'h12);

        // Issue+writeback same pending reg keeps it pending
        cyc();
        drv(0, 0, 0, 1, 3, 0, 3, 0);
        cyc();
        drv(1, 3, 32'h33, 1, 3, 0, 3, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 3, 0);
        @(negedge clk);
        chk("iss_wb_busy", 64'(ifb.rd_busy[0]), 64'h1);
        chk("iss_wb_pend_cnt", 64'(ifb.pend_cnt), 64'h1);
        chk("iss_wb_no_stray", 64'(ifb.wb_stray), 64'h0);
        chk("iss_wb_data", 64'(ifb.rd_data[31:0]), 64'h33);

        // Issue r1, r2, then issue r9 with flush
        drv(0, 0, 0, 1, 1, 0, 9, 1);
        cyc();
        drv(0, 0, 0, 1, 2, 0, 9, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 9, 1);
        @(negedge clk);
        chk("three_pend_cnt", 64'(ifb.pend_cnt), 64'h3);
        drv(0, 0, 0, 1, 9, 1, 9, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 9, 1);
        @(negedge clk);
        chk("flush_pend_cnt", 64'(ifb.pend_cnt), 64'h1);
        chk("flush_busy", 64'(ifb.rd_busy), 64'b01);
        drv(0, 0, 0, 0, 0, 0, 3, 0);
        #1;
        chk("flush_r3_clear", 64'(ifb.rd_busy[0]), 64'h0);
        drv(0, 0, 0, 0, 0, 1, 0, 0);
        cyc();

        // Zero register ignores write and issue
        drv(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0_rd_same", 64'(ifb.rd_data[31:0]), 64'h0);
        chk("r0_busy_same", 64'(ifb.rd_busy[0]), 64'h0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0_rd_after", 64'(ifb.rd_data[31:0]), 64'h0);
        chk("r0_busy_after", 64'(ifb.rd_busy[0]), 64'h0);
        chk("r0_no_stray", 64'(ifb.wb_stray), 64'h0);
        chk("r0_pend_cnt", 64'(ifb.pend_cnt), 64'h0);

        // Stray writeback to non-pending r4
        cyc();
        drv(1, 4, 32'h44, 0, 0, 0, 4, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 4, 0);
        @(negedge clk);
        chk("stray_pulse", 64'(ifb.wb_stray), 64'h1);
        chk("stray_written", 64'(ifb.rd_data[31:0]), 64'h44);
        cyc();
        @(negedge clk);
        chk("stray_one_cycle", 64'(ifb.wb_stray), 64'h0);

        // Ten pending, last cycle also a stray write, then async reset
        for (int r = 10; r < 20; r++) begin
            cyc();
            if (r == 19) drv(1, 20, 32'h55, 1, 5'(r), 0, 4, 10);
            else         drv(0, 0, 0, 1, 5'(r), 0, 4, 10);
        end
        cyc();
        drv(0, 0, 0, 0, 0, 0, 4, 10);
        #1;
        chk("ten_pend_cnt", 64'(ifb.pend_cnt), 64'd10);
        chk("ten_stray", 64'(ifb.wb_stray), 64'h1);
        chk("ten_busy", 64'(ifb.rd_busy), 64'b10);
        rst_n = 1'b0;
        #1;
        chk("async_pend_cnt", 64'(ifb.pend_cnt), 64'h0);
        chk("async_wb_stray", 64'(ifb.wb_stray), 64'h0);
        chk("async_rd_busy", 64'(ifb.rd_busy), 64'h0);
        chk("async_rd_data", 64'(ifb.rd_data), 64'h0);
        drv(1, 11, 32'h77, 1, 11, 0, 11, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 11, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        #1;
        chk("rst_strobe_pend_cnt", 64'(ifb.pend_cnt), 64'h0);
        chk("rst_strobe_busy", 64'(ifb.rd_busy[0]), 64'h0);
        chk("rst_strobe_data", 64'(ifb.rd_data[31:0]), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
